// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline instruction-fetch stage.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } if_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Sequential fetch step; wraps modulo 2^32 by construction.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pipeline_if_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load > bubble.
module if_id_reg
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_hold,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc_plus4;
   logic        r_valid;

   // A bubble keeps the previous PC+4 so ID always sees a sane link value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= 32'h0;
         r_valid    <= 1'b0;
      end else if (i_flush) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_hold) begin
         r_instr    <= r_instr;
         r_pc_plus4 <= r_pc_plus4;
         r_valid    <= r_valid;
      end else if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc_plus4;
         r_valid    <= 1'b1;
      end else begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end
   end

   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage with skid buffer, redirect and drain of in-flight fetches.
// Optional debug outputs are enabled with PIPELINE_IF_DEBUG_EN.
module pipeline_if_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        id_stall,
   input  logic        id_redirect,
   input  logic [31:0] id_redirect_target,
   output logic [31:0] id_instruction,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid
`ifdef PIPELINE_IF_DEBUG_EN
   ,
   output logic [1:0]  debug_state,
   output logic [31:0] debug_fetch_addr,
   output logic [15:0] debug_flush_count
`endif
);

   // Handshake: a fetch completes on a cycle where imem_req=1 and imem_ready=1;
   // imem_addr stays put until then, and imem_rdata is only used on that cycle.
   if_state_t   r_state;
   logic [31:0] r_fetch_addr;
   logic [31:0] r_skid;
   logic [31:0] r_target;
   logic        r_req;

   logic        w_redir;
   logic        w_ready;
   logic [31:0] w_target;
   logic [31:0] w_addr_inc;
   logic        w_load;
   logic [31:0] w_load_instr;

   // Stall beats redirect: a redirect seen during a stall is ignored.
   assign w_redir    = id_redirect & ~id_stall;
   assign w_ready    = imem_ready & r_req;
   assign w_target   = id_redirect_target & ~32'd3;
   assign w_addr_inc = next_pc(r_fetch_addr);

   always_comb begin
      w_load       = 1'b0;
      w_load_instr = imem_rdata;
      case (r_state)
         FETCH: begin
            w_load       = w_ready;
            w_load_instr = imem_rdata;
         end
         HOLD: begin
            w_load       = 1'b1;
            w_load_instr = r_skid;
         end
         default: begin
            w_load       = 1'b0;
            w_load_instr = imem_rdata;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FETCH;
         r_fetch_addr <= RESET_PC;
         r_skid       <= 32'h0;
         r_target     <= 32'h0;
         r_req        <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               r_req <= 1'b1;
               if (w_redir) begin
                  // No outstanding request means the target can be fetched right away.
                  if (w_ready || !r_req) begin
                     r_fetch_addr <= w_target;
                  end else begin
                     r_target <= w_target;
                     r_state  <= DRAIN;
                  end
               end else if (id_stall) begin
                  if (w_ready) begin
                     r_skid  <= imem_rdata;
                     r_state <= HOLD;
                     r_req   <= 1'b0;
                  end
               end else if (w_ready) begin
                  r_fetch_addr <= w_addr_inc;
               end
            end
            HOLD: begin
               if (w_redir) begin
                  r_fetch_addr <= w_target;
                  r_state      <= FETCH;
                  r_req        <= 1'b1;
               end else if (!id_stall) begin
                  r_fetch_addr <= w_addr_inc;
                  r_state      <= FETCH;
                  r_req        <= 1'b1;
               end
            end
            DRAIN: begin
               r_req <= 1'b1;
               if (w_ready) begin
                  r_fetch_addr <= w_redir ? w_target : r_target;
                  r_state      <= FETCH;
               end else if (w_redir) begin
                  r_target <= w_target;
               end
            end
            default: begin
               r_state <= FETCH;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_hold     (id_stall),
      .i_flush    (w_redir),
      .i_load     (w_load),
      .i_instr    (w_load_instr),
      .i_pc_plus4 (w_addr_inc),
      .o_instr    (id_instruction),
      .o_pc_plus4 (id_pc_plus4),
      .o_valid    (id_valid)
   );

   assign imem_req  = r_req;
   assign imem_addr = r_fetch_addr;

`ifdef PIPELINE_IF_DEBUG_EN
   logic [15:0] r_flush_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush_count <= 16'h0;
      end else if (w_redir && (r_flush_count != 16'hFFFF)) begin
         r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign debug_state       = r_state;
   assign debug_fetch_addr  = r_fetch_addr;
   assign debug_flush_count = r_flush_count;
`endif

endmodule
